// File: rtl/msg_scroller.sv
// Message scroller: stores up to MSG_LEN symbols and shows a WIN_LEN-symbol window that holds, rotates or bounces on each step.
// Latency: window/offset/wrap are registered from next-state, so they update on the same edge; there is no backpressure and every step is consumed.
module msg_scroller #(
    parameter int               SYM_W     = 4,
    parameter int               MSG_LEN   = 10,
    parameter int               WIN_LEN   = 8,
    parameter logic [SYM_W-1:0] BLANK_SYM = 4'hB,
    localparam int              LEN_W     = $clog2(MSG_LEN + 1),
    localparam int              OFF_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       step,
    input  logic                       load,
    input  logic [1:0]                 mode,
    input  logic [MSG_LEN*SYM_W-1:0]   msg_in,
    input  logic [LEN_W-1:0]           len_in,
    output logic [WIN_LEN*SYM_W-1:0]   window,
    output logic [OFF_W-1:0]           offset,
    output logic                       wrap
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_LEFT   = 2'b01,
        MODE_RIGHT  = 2'b10,
        MODE_BOUNCE = 2'b11
    } mode_t;

    logic [SYM_W-1:0]         m     [MSG_LEN];
    logic [LEN_W-1:0]         len;
    logic                     dir;

    logic [SYM_W-1:0]         nxt_m [MSG_LEN];
    logic [LEN_W-1:0]         nxt_len;
    logic                     nxt_dir;
    logic                     nxt_wrap;
    logic [WIN_LEN*SYM_W-1:0] nxt_win;
    int                       nxt_o;
    int                       cur_l;
    int                       cur_o;
    int                       bmax;
    int                       win_l;
    int                       ix;

    // Next-state of the message store, length, offset and bounce direction.
    always_comb begin
        nxt_m    = m;
        nxt_len  = len;
        nxt_dir  = dir;
        nxt_wrap = 1'b0;
        cur_l    = int'(len);
        cur_o    = int'(offset);
        nxt_o    = cur_o;
        bmax     = (cur_l > WIN_LEN) ? cur_l - WIN_LEN : 0;

        if (load) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                nxt_m[i] = msg_in[(MSG_LEN-1-i)*SYM_W +: SYM_W];
            end
            nxt_len = (int'(len_in) > MSG_LEN) ? LEN_W'(MSG_LEN) : len_in;
            nxt_o   = 0;
            nxt_dir = 1'b0;
        end else if (step && cur_l != 0) begin
            case (mode_t'(mode))
                MODE_HOLD: begin
                end
                MODE_LEFT: begin
                    nxt_o    = (cur_o + 1 == cur_l) ? 0 : cur_o + 1;
                    nxt_wrap = (nxt_o == 0);
                end
                MODE_RIGHT: begin
                    nxt_o    = (cur_o == 0) ? cur_l - 1 : cur_o - 1;
                    nxt_wrap = (nxt_o == 0);
                end
                MODE_BOUNCE: begin
                    if (bmax == 0) begin
                        nxt_o = 0;
                    end else if (cur_o > bmax) begin
                        nxt_o    = bmax;
                        nxt_dir  = 1'b1;
                        nxt_wrap = 1'b1;
                    // A stale direction sitting on an end stop turns around instead of overrunning.
                    end else if (dir ? (cur_o == 0) : (cur_o != bmax)) begin
                        nxt_o    = cur_o + 1;
                        nxt_dir  = (cur_o + 1 == bmax);
                        nxt_wrap = (cur_o + 1 == bmax);
                    end else begin
                        nxt_o    = cur_o - 1;
                        nxt_dir  = (cur_o - 1 != 0);
                        nxt_wrap = (cur_o - 1 == 0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Window built from next-state so it moves on the same edge as offset; short messages repeat.
    always_comb begin
        nxt_win = '0;
        win_l   = int'(nxt_len);
        ix      = nxt_o;
        for (int k = 0; k < WIN_LEN; k++) begin
            if (win_l == 0) begin
                nxt_win[(WIN_LEN-1-k)*SYM_W +: SYM_W] = BLANK_SYM;
            end else begin
                nxt_win[(WIN_LEN-1-k)*SYM_W +: SYM_W] = nxt_m[OFF_W'(ix)];
                ix = (ix + 1 == win_l) ? 0 : ix + 1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                m[i] <= BLANK_SYM;
            end
            len    <= LEN_W'(MSG_LEN);
            offset <= '0;
            dir    <= 1'b0;
            wrap   <= 1'b0;
            window <= {WIN_LEN{BLANK_SYM}};
        end else begin
            m      <= nxt_m;
            len    <= nxt_len;
            offset <= OFF_W'(nxt_o);
            dir    <= nxt_dir;
            wrap   <= nxt_wrap;
            window <= nxt_win;
        end
    end

endmodule

// File: tb/tb_msg_scroller.sv
// Scoreboard bench for msg_scroller at default parameters.
module tb_msg_scroller;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        step = 1'b0;
    logic        load = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [39:0] msg_in = 40'h0123456789;
    logic [3:0]  len_in = 4'd10;
    logic [31:0] window;
    logic [3:0]  offset;
    logic        wrap;

    typedef struct packed {
        logic [31:0] w;
        logic [3:0]  o;
        logic        wr;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          mlen = 10;
    string       phase = "init";

    msg_scroller dut (
        .clk    (clk),
        .clr    (clr),
        .step   (step),
        .load   (load),
        .mode   (mode),
        .msg_in (msg_in),
        .len_in (len_in),
        .window (window),
        .offset (offset),
        .wrap   (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s/%s got=%h exp=%h", phase, tag, got, exp);
        end
    endtask

    // Reference window: slot k shows symbol (off+k) mod ln of the test message.
    function automatic logic [31:0] exp_win(input int ln, input int off);
        logic [31:0] w;
        logic [39:0] msg;
        int          i;
        w   = '0;
        msg = 40'h0123456789;
        if (ln == 0) return 32'hBBBBBBBB;
        for (int k = 0; k < 8; k++) begin
            i = (off + k) % ln;
            w = {w[27:0], msg[(9-i)*4 +: 4]};
        end
        return w;
    endfunction

    task automatic tick(input logic c, input logic l, input logic s, input logic [1:0] md,
                        input logic [3:0] ln, input logic [31:0] ew, input logic [3:0] eo,
                        input logic ewr);
        exp_t e;
        clr    = c;
        load   = l;
        step   = s;
        mode   = md;
        len_in = ln;
        e.w    = ew;
        e.o    = eo;
        e.wr   = ewr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("window", 40'(window), 40'(e.w));
        chk("offset", 40'(offset), 40'(e.o));
        chk("wrap",   40'(wrap),   40'(e.wr));
        clr  = 1'b0;
        load = 1'b0;
        step = 1'b0;
    endtask

    task automatic stp(input logic [1:0] md, input int eo, input logic ewr);
        tick(1'b0, 1'b0, 1'b1, md, 4'd10, exp_win(mlen, eo), 4'(eo), ewr);
    endtask

    task automatic ld(input int ln);
        mlen = (ln > 10) ? 10 : ln;
        tick(1'b0, 1'b1, 1'b0, 2'b00, 4'(ln), exp_win(mlen, 0), 4'd0, 1'b0);
    endtask

    initial begin
        phase = "reset";
        tick(1'b1, 1'b1, 1'b1, 2'b01, 4'd10, 32'hBBBBBBBB, 4'd0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 2'b01, 4'd10, 32'hBBBBBBBB, 4'd0, 1'b0);

        phase = "left";
        mlen = 10;
        tick(1'b0, 1'b1, 1'b0, 2'b01, 4'd10, 32'h01234567, 4'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b01, 4'd10, 32'h12345678, 4'd1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b01, 4'd10, 32'h23456789, 4'd2, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b01, 4'd10, 32'h34567890, 4'd3, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 2'b01, 4'd10, 32'h34567890, 4'd3, 1'b0);
        for (int i = 4; i < 10; i++) stp(2'b01, i, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b01, 4'd10, 32'h01234567, 4'd0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 2'b01, 4'd10, 32'h01234567, 4'd0, 1'b0);

        phase = "right";
        ld(10);
        tick(1'b0, 1'b0, 1'b1, 2'b10, 4'd10, 32'h90123456, 4'd9, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b10, 4'd10, 32'h89012345, 4'd8, 1'b0);
        for (int i = 7; i > 0; i--) stp(2'b10, i, 1'b0);
        stp(2'b10, 0, 1'b1);
        stp(2'b00, 0, 1'b0);

        phase = "bounce";
        ld(10);
        stp(2'b11, 1, 1'b0);
        stp(2'b11, 2, 1'b1);
        stp(2'b11, 1, 1'b0);
        stp(2'b11, 0, 1'b1);
        stp(2'b11, 1, 1'b0);
        phase = "bounce_clamp";
        ld(10);
        for (int i = 1; i <= 5; i++) stp(2'b01, i, 1'b0);
        stp(2'b11, 2, 1'b1);
        stp(2'b11, 1, 1'b0);

        phase = "short";
        mlen = 3;
        tick(1'b0, 1'b1, 1'b0, 2'b00, 4'd3, 32'h01201201, 4'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b01, 4'd10, 32'h12012012, 4'd1, 1'b0);
        stp(2'b01, 2, 1'b0);
        stp(2'b01, 0, 1'b1);
        stp(2'b11, 0, 1'b0);
        ld(1);
        stp(2'b01, 0, 1'b1);
        stp(2'b10, 0, 1'b1);

        phase = "zero";
        ld(0);
        stp(2'b01, 0, 1'b0);
        stp(2'b10, 0, 1'b0);
        stp(2'b11, 0, 1'b0);

        phase = "clamp";
        ld(15);
        tick(1'b0, 1'b0, 1'b1, 2'b10, 4'd10, 32'h90123456, 4'd9, 1'b0);

        phase = "collide";
        ld(10);
        stp(2'b01, 1, 1'b0);
        stp(2'b01, 2, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 2'b01, 4'd10, 32'h01234567, 4'd0, 1'b0);
        for (int i = 1; i <= 4; i++) stp(2'b01, i, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 2'b01, 4'd10, 32'hBBBBBBBB, 4'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 2'b01, 4'd10, 32'hBBBBBBBB, 4'd1, 1'b0);
        ld(10);
        stp(2'b01, 1, 1'b0);

        phase = "end";
        chk("sb_empty", 40'(sb.size()), 40'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
